dcache_controller: RTL and testbench
====================================

# dcache_controller

Control stage for the L1 data cache. Sits between the CPU load/store port and the 2-way, 16-set, 32-byte-line cache SRAM.
- Splits CPU addresses into tag, index and word offset, and drives lookups and writes into the SRAM.
- Serves read hits and write hits directly.
- On a miss, writes back a dirty victim if needed and refills the line from data memory, stalling the CPU until the access can complete.

## Interface
- No parameters. Widths are fixed constants in the package: addr 32, word 32, line 256, index 4, tag 23, SRAM tag word 25 ({valid, dirty, tag[22:0]}).
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  CPU access request
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address: tag [31:9], index [8:5], word [4:2]
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold its request stable while this is high
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  tag written and compared
- sram_data_o  out  256  line written
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe
- sram_tag_i  in  25  tag of the hit way, else the LRU victim
- sram_data_i  in  256  line of the hit way, else the LRU victim
- sram_hit_i  in  1  lookup hit
- mem_enable_o  out  1  memory request, held level until ack
- mem_write_o  out  1  1 = write-back, 0 = refill
- mem_addr_o  out  32  line-aligned address, [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.

IDLE
- sram_addr_o = cpu_addr_i[8:5].
- sram_tag_o[22:0] = cpu_addr_i[31:9].
- sram_enable_o = cpu_req_i.
- Read hit: cpu_data_o = sram_data_i[32*w+31 : 32*w], where w = cpu_addr_i[4:2]; no stall.
- Write hit:
  - sram_write_o = 1.
  - sram_data_o = sram_data_i with word w replaced by cpu_data_i.
  - sram_tag_o = {1, 1, tag}.
  - No stall.
- Miss (cpu_req_i && !sram_hit_i): go to MISS; stall.

MISS
- If sram_tag_i[24] and sram_tag_i[23] (valid and dirty victim): go to WRITEBACK.
- Otherwise: go to REFILL.

WRITEBACK
- mem_enable_o = 1, mem_write_o = 1.
- mem_addr_o = {sram_tag_i[22:0], index, 5'b0}.
- mem_data_o = sram_data_i.
- On mem_ack_i: go to REFILL.

REFILL
- mem_enable_o = 1, mem_write_o = 0.
- mem_addr_o = {cpu tag, index, 5'b0}.
- On mem_ack_i:
  - sram_write_o = 1, sram_data_o = mem_data_i.
  - sram_tag_o = {1, 0, cpu tag}.
  - Go to REFILL_DONE.

REFILL_DONE
- Hold for one cycle, then go to IDLE.
- The re-lookup in IDLE now hits and completes the original load or store.

Rules
- cpu_stall_o = (state != IDLE) || (cpu_req_i && !sram_hit_i).
- mem_ack_i is ignored in IDLE, MISS and REFILL_DONE.
- No new CPU request is accepted while state != IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - mem_enable_o = 0, mem_write_o = 0, sram_write_o = 0.
  - cpu_stall_o = 0 when no request is present.
  - Remaining outputs are 0.
- Hit latency: 0 cycles. Read data is combinational in the request cycle; a write commits on the next clk_i edge.
- Clean miss: 1 (MISS) + N (REFILL, ack on cycle N) + 1 (REFILL_DONE) + 1 (IDLE hit).
- Dirty miss: adds the write-back cycles, ending on the write-back ack.
- mem_enable_o, mem_write_o, mem_addr_o and mem_data_o stay stable from request until the ack cycle, inclusive.
- Reset asserted mid-miss: return to IDLE and drop mem_enable_o asynchronously; any later stray ack is ignored.
- Write-back ack and refill request: mem_enable_o stays high across the WRITEBACK→REFILL transition, and mem_write_o falls.

## Structure
- dcache_pkg holds the width constants, the address field slice positions, the state enum and the tag-bit indices (VALID = 24, DIRTY = 23).
- One sub-module, dcache_word_merge: combinational insertion of a 32-bit word into a 256-bit line at word index w.

## Test plan
- Load hit: line preloaded at 0x0000_0040 with word1 = 0xDEADBEEF; load 0x44 → cpu_data_o = 0xDEADBEEF in the same cycle, stall = 0.
- Clean load miss:
  - Stimulus: load 0x0000_1000, memory acks after 10 cycles with word0 = 0x12345678.
  - Response: REFILL mem_addr_o = 0x1000, mem_write_o = 0; stall ends with 0x12345678; SRAM tag written as {1, 0, tag}.
- Store hit:
  - Stimulus: store 0xCAFEF00D to 0x1008 after the refill above.
  - Response: sram_write_o = 1, word2 replaced, SRAM tag written as {1, 1, tag}; mem_enable_o stays 0.
- Dirty eviction:
  - Stimulus: victim at set 0 is dirty with tag 0x1; load 0x0000_0400 (set 0, tag 0x2).
  - Response:
    - WRITEBACK mem_addr_o = 0x200, mem_write_o = 1.
    - After ack, REFILL mem_addr_o = 0x400.
    - Load completes with the refilled data.
- Reset during REFILL: assert rst_i while mem_enable_o = 1 → mem_enable_o falls immediately, state is IDLE, a subsequent ack causes no SRAM write.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths, address field positions, FSM state codes and tag-bit indices
// for the L1 data cache controller.
package dcache_pkg;

  localparam int ADDR_W  = 32;
  localparam int WORD_W  = 32;
  localparam int LINE_W  = 256;
  localparam int IDX_W   = 4;
  localparam int TAG_W   = 23;
  localparam int STAG_W  = 25;
  localparam int WSEL_W  = 3;
  localparam int WORDS   = LINE_W / WORD_W;

  // cpu address: tag [31:9], index [8:5], word [4:2]
  localparam int TAG_LSB  = 9;
  localparam int IDX_LSB  = 5;
  localparam int WORD_LSB = 2;

  // SRAM tag word layout {valid, dirty, tag}
  localparam int VALID = 24;
  localparam int DIRTY = 23;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_MISS        = 3'd1;
  localparam logic [2:0] S_WRITEBACK   = 3'd2;
  localparam logic [2:0] S_REFILL      = 3'd3;
  localparam logic [2:0] S_REFILL_DONE = 3'd4;

  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] w);
    return line[w*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Replaces one 32-bit word of a 256-bit cache line, selected by word index.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WSEL_W-1:0] sel,
  input  logic [WORD_W-1:0] word,
  output logic [LINE_W-1:0] merged
);

  for (genvar i = 0; i < WORDS; i++) begin : g_word
    assign merged[i*WORD_W +: WORD_W] = (sel == WSEL_W'(i)) ? word : line[i*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/dcache_controller.sv
// L1 data cache control: hit service, dirty write-back and line refill,
// stalling the CPU port until a missed access can complete.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [STAG_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [STAG_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  logic [2:0]        state, state_nxt;
  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [WSEL_W-1:0] cpu_word;
  logic [LINE_W-1:0] merged_line;
  logic              unused_ok;

  assign cpu_tag   = cpu_addr_i[ADDR_W-1:TAG_LSB];
  assign cpu_idx   = cpu_addr_i[TAG_LSB-1:IDX_LSB];
  assign cpu_word  = cpu_addr_i[IDX_LSB-1:WORD_LSB];
  assign unused_ok = ^cpu_addr_i[WORD_LSB-1:0];

  dcache_word_merge u_merge (
    .line   (sram_data_i),
    .sel    (cpu_word),
    .word   (cpu_data_i),
    .merged (merged_line)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign cpu_stall_o = (state != S_IDLE) || (cpu_req_i && !sram_hit_i);

  // All outputs decode from state, so an async reset drops mem_enable_o at once.
  always_comb begin
    state_nxt     = state;
    cpu_data_o    = '0;
    sram_addr_o   = cpu_idx;
    sram_tag_o    = {2'b00, cpu_tag};
    sram_data_o   = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    case (state)
      S_IDLE: begin
        sram_enable_o = cpu_req_i;
        if (cpu_req_i) begin
          if (sram_hit_i) begin
            cpu_data_o = word_sel(sram_data_i, cpu_word);
            if (cpu_we_i) begin
              sram_write_o = 1'b1;
              sram_data_o  = merged_line;
              sram_tag_o   = {1'b1, 1'b1, cpu_tag};
            end
          end else begin
            state_nxt = S_MISS;
          end
        end
      end
      S_MISS: begin
        // keep the lookup live so the victim's tag is presented
        sram_enable_o = 1'b1;
        state_nxt = (sram_tag_i[VALID] && sram_tag_i[DIRTY]) ? S_WRITEBACK : S_REFILL;
      end
      S_WRITEBACK: begin
        sram_enable_o = 1'b1;
        mem_enable_o  = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = {sram_tag_i[TAG_W-1:0], cpu_idx, {IDX_LSB{1'b0}}};
        mem_data_o    = sram_data_i;
        if (mem_ack_i) state_nxt = S_REFILL;
      end
      S_REFILL: begin
        sram_enable_o = 1'b1;
        mem_enable_o  = 1'b1;
        mem_addr_o    = {cpu_tag, cpu_idx, {IDX_LSB{1'b0}}};
        if (mem_ack_i) begin
          sram_write_o = 1'b1;
          sram_data_o  = mem_data_i;
          sram_tag_o   = {1'b1, 1'b0, cpu_tag};
          state_nxt    = S_REFILL_DONE;
        end
      end
      S_REFILL_DONE: state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench: 2-way LRU SRAM model, line-granular memory with random ack delays,
// and a flat word-addressed reference of architectural memory contents.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- SRAM model: [way][set], m_lru = way evicted next
  logic [22:0]  m_tag [2][16];
  logic         m_val [2][16];
  logic         m_dty [2][16];
  logic [255:0] m_dat [2][16];
  logic         m_lru [16];
  logic         h0, h1, hway;

  always_comb begin
    h0 = m_val[0][sram_addr_o] && (m_tag[0][sram_addr_o] == sram_tag_o[22:0]);
    h1 = m_val[1][sram_addr_o] && (m_tag[1][sram_addr_o] == sram_tag_o[22:0]);
    sram_hit_i  = h0 | h1;
    hway        = h0 ? 1'b0 : (h1 ? 1'b1 : m_lru[sram_addr_o]);
    sram_tag_i  = {m_val[hway][sram_addr_o], m_dty[hway][sram_addr_o], m_tag[hway][sram_addr_o]};
    sram_data_i = m_dat[hway][sram_addr_o];
  end

  // Advance one clock; the SRAM model commits whatever the DUT drove at the edge.
  task automatic tick();
    logic en, wr, h, wy;
    logic [3:0] s;
    logic [24:0] t;
    logic [255:0] d;
    en = sram_enable_o; wr = sram_write_o; h = sram_hit_i; wy = hway;
    s = sram_addr_o; t = sram_tag_o; d = sram_data_o;
    @(posedge clk_i);
    if (en) begin
      if (wr) begin
        m_val[wy][s] = t[24]; m_dty[wy][s] = t[23]; m_tag[wy][s] = t[22:0]; m_dat[wy][s] = d;
      end
      if (h || wr) m_lru[s] = ~wy;
    end
    #1;
  endtask

  // ---------------- memory and architectural reference
  logic [255:0] mem_q [logic [31:0]];
  logic [31:0]  ref_q [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [255:0] get_mem(input logic [31:0] la);
    return mem_q.exists(la) ? mem_q[la] : init_line(la);
  endfunction

  function automatic logic [31:0] get_ref(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return ref_q.exists(k) ? ref_q[k] : init_word(k);
  endfunction

  // One CPU access; dw/dr are the write-back and refill ack delays in cycles.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int dw, input int dr);
    logic [3:0]   s;
    logic [22:0]  tg;
    logic [2:0]   w;
    logic [31:0]  la, wb_addr, ra;
    logic [255:0] wb_data, rd;
    logic         hit, vw, do_wb, active, rw, done;
    int           exp_stall, stalls, cnt, nreq, cyc;
    s = addr[8:5]; tg = addr[31:9]; w = addr[4:2]; la = {addr[31:5], 5'b0};
    hit     = (m_val[0][s] && m_tag[0][s] == tg) || (m_val[1][s] && m_tag[1][s] == tg);
    vw      = m_lru[s];
    do_wb   = !hit && m_val[vw][s] && m_dty[vw][s];
    wb_addr = {m_tag[vw][s], s, 5'b0};
    wb_data = m_dat[vw][s];
    exp_stall = hit ? 0 : (3 + dr + (do_wb ? dw : 0));
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wd;
    stalls = 0; cnt = 0; nreq = 0; active = 0; done = 0; cyc = 0; rw = 0; ra = '0; rd = '0;
    while (!done && cyc < 300) begin
      cyc++;
      @(negedge clk_i);
      if (!cpu_stall_o) begin
        done = 1;
        chk("stall_cycles", 256'(stalls), 256'(exp_stall));
        if (!we) chk("load_data", cpu_data_o, get_ref(addr));
        else begin
          chk("st_sram_wr", sram_write_o, 1'b1);
          chk("st_tag", sram_tag_o, {2'b11, tg});
          chk("st_word", sram_data_o[w*32 +: 32], wd);
          chk("st_no_mem", mem_enable_o, 1'b0);
        end
      end else begin
        stalls++;
        if (mem_enable_o) begin
          if (!active) begin
            active = 1; cnt = 0; ra = mem_addr_o; rw = mem_write_o; rd = mem_data_o;
            chk("req_kind", mem_write_o, (nreq == 0) && do_wb);
            if (mem_write_o) begin
              chk("wb_addr", mem_addr_o, wb_addr);
              chk("wb_data", mem_data_o, wb_data);
            end else chk("rf_addr", mem_addr_o, la);
          end else begin
            chk("mem_stable", {mem_write_o, mem_addr_o}, {rw, ra});
            if (rw) chk("wb_stable", mem_data_o, rd);
          end
          cnt++;
          if (cnt == (rw ? dw : dr)) begin
            mem_ack_i = 1'b1;
            if (rw) mem_q[ra] = mem_data_o;
            else    mem_data_i = get_mem(la);
            active = 0; nreq++;
          end
        end
      end
      #1;
      if (mem_ack_i && !rw) begin
        chk("rf_sram_wr", sram_write_o, 1'b1);
        chk("rf_tag", sram_tag_o, {2'b10, tg});
        chk("rf_data", sram_data_o, mem_data_i);
      end
      tick();
      mem_ack_i = 1'b0; mem_data_i = '0;
    end
    chk("access_done", done, 1'b1);
    if (we) ref_q[{addr[31:2], 2'b00}] = wd;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  initial begin
    logic [255:0] line, snap;
    logic [31:0]  a;
    int           cyc;
    bit           found;
    for (int wy = 0; wy < 2; wy++)
      for (int st = 0; st < 16; st++) begin
        m_val[wy][st] = 0; m_dty[wy][st] = 0; m_tag[wy][st] = '0; m_dat[wy][st] = '0;
      end
    for (int st = 0; st < 16; st++) m_lru[st] = 0;
    rst_i = 1'b1; cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
    #2;
    chk("rst_mem_en", mem_enable_o, 1'b0);
    chk("rst_mem_wr", mem_write_o, 1'b0);
    chk("rst_sram_wr", sram_write_o, 1'b0);
    chk("rst_sram_en", sram_enable_o, 1'b0);
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_outs", {cpu_data_o, mem_addr_o, sram_tag_o, 3'b0, sram_addr_o}, '0);
    chk("rst_lines", mem_data_o | sram_data_o, '0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // load hit: preloaded clean line at 0x40 (set 2, tag 0)
    line = init_line(32'h40); line[63:32] = 32'hDEADBEEF;
    mem_q[32'h40] = line;
    for (int i = 0; i < 8; i++) ref_q[32'h40 + 32'(i * 4)] = line[i*32 +: 32];
    m_val[0][2] = 1; m_tag[0][2] = '0; m_dat[0][2] = line;
    access(1'b0, 32'h44, '0, 1, 1);

    // dirty eviction: set 0 holds dirty tag 1, load tag 2
    line = {8{32'hB0B0_0000}} ^ init_line(32'h200);
    for (int i = 0; i < 8; i++) ref_q[32'h200 + 32'(i * 4)] = line[i*32 +: 32];
    m_val[0][0] = 1; m_dty[0][0] = 1; m_tag[0][0] = 23'd1; m_dat[0][0] = line; m_lru[0] = 0;
    access(1'b0, 32'h400, '0, 3, 4);
    chk("wb_mem_line", get_mem(32'h200), line);

    // clean load miss with a 10-cycle refill, then store hit and read-back
    line = init_line(32'h1000); line[31:0] = 32'h12345678;
    mem_q[32'h1000] = line; ref_q[32'h1000] = 32'h12345678;
    access(1'b0, 32'h1000, '0, 1, 10);
    access(1'b1, 32'h1008, 32'hCAFEF00D, 1, 1);
    access(1'b0, 32'h1008, '0, 1, 1);

    // reset asserted mid-refill, then a stray ack
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h2000;
    found = 0; cyc = 0;
    while (!found && cyc < 20) begin
      cyc++;
      @(negedge clk_i);
      if (mem_enable_o && !mem_write_o) found = 1;
      else begin #1; tick(); end
    end
    chk("rf_reached", found, 1'b1);
    snap = {m_dat[0][0][127:0] ^ m_dat[1][0][127:0], 80'b0, m_val[0][0], m_val[1][0],
            m_tag[0][0], m_tag[1][0]};
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_mem_en", mem_enable_o, 1'b0);
    chk("rst_mid_mem_wr", mem_write_o, 1'b0);
    cpu_req_i = 0;
    #1 chk("rst_mid_stall", cpu_stall_o, 1'b0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    mem_ack_i = 1'b1; mem_data_i = {8{32'hBAD0_BAD0}};
    #1 chk("stray_sram_wr", sram_write_o, 1'b0);
    chk("stray_mem_en", mem_enable_o, 1'b0);
    tick();
    mem_ack_i = 0; mem_data_i = '0;
    chk("stray_sram_state", {m_dat[0][0][127:0] ^ m_dat[1][0][127:0], 80'b0, m_val[0][0],
                             m_val[1][0], m_tag[0][0], m_tag[1][0]}, snap);

    // random traffic over a few tags and sets to force hits, clean and dirty misses
    for (int n = 0; n < 250; n++) begin
      a = {20'($urandom_range(0, 5)), 3'b0, 4'($urandom_range(0, 3)), 3'($urandom), 2'b00};
      a = {a[31:9] >> 3, a[8:0]};
      access(1'($urandom), a, $urandom, $urandom_range(1, 5), $urandom_range(1, 5));
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
